// File: rtl/lr_pkg.sv
// Types and constants shared by the logistic-regression pipeline: window feeder,
// theta header consumer and inner-product stage.
package lr_pkg;
  localparam int FEAT_W = 32;
  localparam int N_FEAT = 40;

  typedef logic [FEAT_W-1:0] feat_t;

  localparam feat_t BIAS_ONE = feat_t'(1);

  typedef struct packed {
    logic  sof;
    feat_t data;
  } sample_t;
endpackage

// File: rtl/feature_window_buffer_window_ctrl.sv
// Window occupancy and stride bookkeeping; decides when a full window is loaded
// into the output register and drives the valid/ready handshake.
module window_ctrl
  import lr_pkg::*;
#(
  parameter int WINDOW = N_FEAT,
  parameter int STRIDE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic in_sof,
  input  logic out_ready,
  output logic in_ready,
  output logic out_valid,
  output logic accept,
  output logic take,
  output logic emit
);
  localparam int CW = $clog2(WINDOW + 1);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t FULL   = cnt_t'(WINDOW);
  localparam cnt_t RELOAD = cnt_t'(STRIDE - 1);

  cnt_t fill, fill_next, stride_cnt;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign take     = out_valid && out_ready;

  always_comb begin
    fill_next = fill;
    if (in_sof)           fill_next = cnt_t'(1);
    else if (fill != FULL) fill_next = fill + cnt_t'(1);
  end

  // A restart clears the stride phase, so the frame's first window waits for a full fill.
  assign emit = accept && (fill_next == FULL) && (in_sof || stride_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill       <= '0;
      stride_cnt <= '0;
      out_valid  <= 1'b0;
    end else begin
      if (accept) begin
        fill <= fill_next;
        if (emit)                                       stride_cnt <= RELOAD;
        else if (in_sof)                                stride_cnt <= '0;
        else if (fill_next == FULL && stride_cnt != '0) stride_cnt <= stride_cnt - cnt_t'(1);
      end
      if (emit)      out_valid <= 1'b1;
      else if (take) out_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/feature_window_buffer.sv
// Sliding window of the last WINDOW samples presented as a registered bias-prefixed
// feature vector for the inner-product stage.
module feature_window_buffer
  import lr_pkg::*;
#(
  parameter int               WIDTH  = FEAT_W,
  parameter int               WINDOW = N_FEAT,
  parameter int               STRIDE = 1,
  parameter logic [WIDTH-1:0] BIAS   = WIDTH'(BIAS_ONE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sof,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] xarray [0:WINDOW],
  output logic [15:0]      window_count
);
  logic accept, take, emit;
  logic [WINDOW:1][WIDTH-1:0] win;

  window_ctrl #(.WINDOW(WINDOW), .STRIDE(STRIDE)) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .accept    (accept),
    .take      (take),
    .emit      (emit)
  );

  // The shift register is the output register: xarray only moves on accept, which
  // cannot happen while a window is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win <= '0;
    end else if (accept) begin
      for (int k = 1; k < WINDOW; k++) win[k] <= in_sof ? '0 : win[k+1];
      win[WINDOW] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    window_count <= '0;
    else if (take) window_count <= window_count + 16'd1;
  end

  assign xarray[0] = BIAS;
  for (genvar k = 1; k <= WINDOW; k++) begin : g_lane
    assign xarray[k] = win[k];
  end
endmodule

// File: tb/tb_feature_window_buffer.sv
// Directed table plus hand sequences and a randomized scoreboard run for the
// feature window buffer, with STRIDE=1 and STRIDE=4 instances on shared stimulus.
module tb_feature_window_buffer;
  localparam int W = 32;
  localparam int N = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_sof = 1'b0, out_ready = 1'b1;
  logic [W-1:0] in_data = '0;

  logic in_ready1, out_valid1, in_ready4, out_valid4;
  logic [W-1:0] xa1 [0:N];
  logic [W-1:0] xa4 [0:N];
  logic [15:0] wc1, wc4;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  feature_window_buffer #(.STRIDE(1)) d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_sof(in_sof), .out_valid(out_valid1),
    .out_ready(out_ready), .xarray(xa1), .window_count(wc1));

  feature_window_buffer #(.STRIDE(4)) d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .in_sof(in_sof), .out_valid(out_valid4),
    .out_ready(out_ready), .xarray(xa4), .window_count(wc4));

  typedef struct {
    bit s4;
    int n;
    int cnt;
    int x1;
    int x40;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0; in_sof = 0; in_data = '0; out_ready = 1;
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
  endtask

  // Feed samples lo..hi back-to-back; value equals index.
  task automatic feed(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      in_valid = 1; in_sof = 0; in_data = W'(i);
      tick();
    end
    in_valid = 0;
  endtask

  initial begin
    vecs[0] = '{s4: 0, n: 40, cnt: 1, x1: 1,  x40: 40};
    vecs[1] = '{s4: 0, n: 41, cnt: 2, x1: 2,  x40: 41};
    vecs[2] = '{s4: 0, n: 39, cnt: 0, x1: 0,  x40: 39};
    vecs[3] = '{s4: 0, n: 45, cnt: 6, x1: 6,  x40: 45};
    vecs[4] = '{s4: 1, n: 52, cnt: 4, x1: 13, x40: 52};
    vecs[5] = '{s4: 1, n: 43, cnt: 1, x1: 4,  x40: 43};
    vecs[6] = '{s4: 1, n: 44, cnt: 2, x1: 5,  x40: 44};

    // Reset state
    do_reset();
    chk("rst out_valid", out_valid1, 0);
    chk("rst window_count", wc1, 0);
    chk("rst x0 bias", xa1[0], 1);
    chk("rst x1", xa1[1], 0);
    chk("rst x40", xa1[N], 0);
    chk("rst in_ready", in_ready1, 1);

    // Table: stream n samples with out_ready=1, one idle cycle lets the last window be taken
    for (int v = 0; v < 7; v++) begin
      do_reset();
      feed(1, vecs[v].n);
      tick();
      if (vecs[v].s4) begin
        chk($sformatf("vec%0d out_valid", v), out_valid4, 0);
        chk($sformatf("vec%0d count", v), wc4, vecs[v].cnt);
        chk($sformatf("vec%0d x0", v), xa4[0], 1);
        chk($sformatf("vec%0d x1", v), xa4[1], vecs[v].x1);
        chk($sformatf("vec%0d x40", v), xa4[N], vecs[v].x40);
      end else begin
        chk($sformatf("vec%0d out_valid", v), out_valid1, 0);
        chk($sformatf("vec%0d count", v), wc1, vecs[v].cnt);
        chk($sformatf("vec%0d x0", v), xa1[0], 1);
        chk($sformatf("vec%0d x1", v), xa1[1], vecs[v].x1);
        chk($sformatf("vec%0d x40", v), xa1[N], vecs[v].x40);
      end
    end

    // First window latency and STRIDE=1 continuation
    do_reset();
    feed(1, 39);
    chk("t1 no window at 39", out_valid1, 0);
    in_valid = 1; in_data = 40;
    #1;
    chk("t1 valid low before edge", out_valid1, 0);
    tick();
    chk("t1 valid after 40", out_valid1, 1);
    chk("t1 x0", xa1[0], 1);
    chk("t1 x1", xa1[1], 1);
    chk("t1 x40", xa1[N], 40);
    in_data = 41;
    tick();
    chk("t1 valid after 41", out_valid1, 1);
    chk("t1 x1 after 41", xa1[1], 2);
    chk("t1 x40 after 41", xa1[N], 41);
    chk("t1 count after 41", wc1, 1);
    in_data = 42;
    tick();
    chk("t1 count after 42", wc1, 2);

    // Backpressure: stalled window frozen, release does take+emit together
    out_ready = 0; in_data = 43;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("t2 in_ready stalled", in_ready1, 0);
      chk("t2 x40 frozen", xa1[N], 42);
      tick();
    end
    chk("t2 count frozen", wc1, 2);
    out_ready = 1;
    #1;
    chk("t2 in_ready on release", in_ready1, 1);
    tick();
    in_valid = 0;
    chk("t2 valid held", out_valid1, 1);
    chk("t2 x40 new", xa1[N], 43);
    chk("t2 x1 new", xa1[1], 4);
    chk("t2 count", wc1, 3);

    // Frame restart on sample 25
    do_reset();
    feed(1, 24);
    in_valid = 1; in_sof = 1; in_data = 25;
    tick();
    in_sof = 0;
    begin
      int early = 0;
      for (int i = 26; i <= 63; i++) begin
        in_valid = 1; in_data = W'(i);
        tick();
        if (out_valid1) early++;
      end
      chk("t4 no early window", early, 0);
    end
    chk("t4 x39 after sof", xa1[2], 25);
    in_data = 64;
    tick();
    in_valid = 0;
    chk("t4 window valid", out_valid1, 1);
    chk("t4 x1 is sof sample", xa1[1], 25);
    chk("t4 x40", xa1[N], 64);

    // Async reset during a stall
    do_reset();
    feed(1, 42);
    out_ready = 0;
    tick(); tick();
    chk("t5 stalled valid", out_valid1, 1);
    chk("t5 count before rst", wc1, 2);
    #3 rst_n = 0;
    #1;
    chk("t5 async valid", out_valid1, 0);
    chk("t5 async count", wc1, 0);
    chk("t5 async x1", xa1[1], 0);
    chk("t5 async x40", xa1[N], 0);
    chk("t5 async x0 bias", xa1[0], 1);
    #2 rst_n = 1;
    out_ready = 1;
    tick();
    begin
      int early = 0;
      for (int i = 1; i <= 39; i++) begin
        in_valid = 1; in_data = W'(100 + i);
        tick();
        if (out_valid1) early++;
      end
      chk("t5 no window after 39", early, 0);
    end
    in_valid = 0;

    // Random handshake against a last-40 scoreboard
    do_reset();
    begin
      logic [W-1:0] hist [$];
      int acc = 0, takes = 0, cyc = 0, bad;
      while (acc < 10000 && cyc < 60000) begin
        in_valid  = ($urandom_range(0, 9) < 7);
        out_ready = ($urandom_range(0, 9) < 7);
        in_sof = 0;
        in_data = $urandom;
        #1;
        chk("t6 in_ready rule", in_ready1, !out_valid1 || out_ready);
        if (out_valid1 && out_ready) begin
          bad = 0;
          if (hist.size() != N) bad = 1;
          else for (int k = 1; k <= N; k++) if (xa1[k] !== hist[k-1]) bad++;
          chk("t6 window contents", bad, 0);
          takes++;
        end
        if (in_valid && in_ready1) begin
          hist.push_back(in_data);
          if (hist.size() > N) void'(hist.pop_front());
          acc++;
        end
        tick();
        cyc++;
      end
      chk("t6 cycle budget", (cyc < 60000), 1);
      in_valid = 0; out_ready = 1;
      #1;
      if (out_valid1) begin
        bad = 0;
        for (int k = 1; k <= N; k++) if (xa1[k] !== hist[k-1]) bad++;
        chk("t6 last window", bad, 0);
        takes++;
      end
      tick();
      chk("t6 windows taken", takes, acc - (N - 1));
      chk("t6 window_count", wc1, 16'(takes));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
